reorder_commit: RTL and testbench
=================================

Name: reorder_commit

Overview:
- In-order retirement buffer directly downstream of the execute stage.
- Dispatch allocates tagged entries in program order. Execute results (ex_result[2]) complete entries out of order.
- Retires up to 2 completed entries per cycle to the register file.
- Squashes all entries younger than an established branch and issues a registered front-end redirect.

Parameters:
- BUF_SIZE_LOG, 3, log2 of entry count (8 entries).
- Tag width is BUF_SIZE_LOG+1: the MSB is the wrap-phase bit; the low bits are the entry index.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- alloc_valid[2]  input  1 each  allocation request; lane 1 honoured only when lane 0 is set
- alloc_rd[2]  input  5 each  destination register per request
- alloc_ready  output  1  the whole request is accepted this cycle
- alloc_tag[2]  output  BUF_SIZE_LOG+1 each  tags granted: tail and tail+1
- results[2]  input  ex_result each  execute-stage results
- commit_valid[2]  output  1 each  entry retires this cycle
- commit_we[2]  output  1 each  register-file write enable (0 for rd==0 or non-EX_NORMAL entries)
- commit_rd[2]  output  5 each  destination register
- commit_value[2]  output  32 each  result value
- redirect_valid  output  1  front-end redirect, registered
- redirect_pc  output  32  redirect target, registered
- empty  output  1  head==tail

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- State:
  - head and tail pointers, BUF_SIZE_LOG+1 bits each.
  - Per entry: valid, done, normal, rd, value.
  - count = tail-head (mod 2^(BUF_SIZE_LOG+1)); full when count == 2^BUF_SIZE_LOG.
- Reset:
  - head=tail=0; all entries have valid=0, done=0.
  - commit_valid=0, redirect_valid=0, redirect_pc=0, empty=1, alloc_ready=1 (when no branch present).
- Allocation:
  - n = number of honoured lanes.
  - alloc_ready = (free >= 2) & no established branch in results this cycle. It is independent of n.
  - Accept when any lane is honoured and alloc_ready=1: write entries tail..tail+n-1 (valid=1, done=0, rd), then tail += n.
  - All-or-nothing: no partial grants.
- Writeback, per lane with results[i].is_valid:
  - Accept only if the tag lies in the live range [head, tail), phase bit included, and the entry is valid.
  - On accept: done=1; value=result; normal=(mode==EX_NORMAL).
  - Otherwise drop silently (stale or squashed).
- Branch squash:
  - Applies to an accepted lane with is_branch_established.
  - If both lanes qualify, the lane whose tag is older (smaller tag-head) wins.
  - At the edge: tail = winner_tag+1; entries in winner_tag+1..old tail get valid=0; the branch entry itself is kept and marked done.
  - Next cycle: redirect_valid=1 for exactly one cycle, redirect_pc=winner jumped_to.
  - Allocation in the squash cycle is blocked (alloc_ready=0).
- Commit:
  - Combinational from registered state.
  - Lane 0 = head entry if valid & done. Lane 1 = head+1 if lane 0 commits and head+1 is valid & done and within [head, tail).
  - head advances by the number committed at the edge; retired entries are cleared.
  - A result written at edge N is committable in cycle N+1 (minimum one-cycle writeback-to-commit latency).
- Simultaneous events:
  - Commit, writeback, allocation and squash may share one edge.
  - Commit only touches entries at or older than any squash point, so these never conflict.
  - Writeback to an entry being squashed in the same cycle is discarded.
  - A buffer that is full and retires 2 in the same cycle still reports alloc_ready=0, because free is computed from the pre-edge state.
- Wrap-around: pointers are modulo 2^(BUF_SIZE_LOG+1); index = low BUF_SIZE_LOG bits.
- Reset mid-operation: everything is cleared at the next edge; in-flight results arriving after reset are dropped because of the range check.

Test Plan:
1. Reset, then idle -> alloc_ready=1, alloc_tag={0,1}, empty=1, commit_valid=00, redirect_valid=0.
2. Allocate rd5, rd6; write back tag1=0xBB, then tag0=0xAA next cycle -> one cycle later commit lanes 0/1 = (rd5, 0xAA), (rd6, 0xBB) together; empty=1 afterwards.
3. Allocate 7 entries, then request 1 lane -> alloc_ready=0, tail unchanged. Commit one, then request 2 -> accepted; full; alloc_ready=0 with 0 free.
4. Entries 0..5 live; branch result tag2 with jumped_to=0x100 -> tail=3, entries 3..5 invalid; next cycle redirect_valid=1, redirect_pc=0x100. A later writeback to tag4 is ignored.
5. Both lanes branch: tags 4 and 2, head=1 -> squash at 2, redirect_pc=lane-1 target. Allocation request in that cycle rejected.
6. Run 12 allocate/commit pairs (phase wrap) -> tags 8..11 carry MSB=1 and commit correctly. A result with tag 0x1 (stale phase, head=0x9) is dropped.

Source files
------------

// File: rtl/reorder_commit.sv
// In-order retirement buffer: tagged allocation, out-of-order completion,
// dual in-order commit and youngest-entry squash on an established branch.
package reorder_commit_pkg;
  localparam int RC_BUF_SIZE_LOG = 3;

  typedef enum logic [1:0] {
    EX_NORMAL    = 2'd0,
    EX_EXCEPTION = 2'd1,
    EX_INTERRUPT = 2'd2,
    EX_HALT      = 2'd3
  } ex_mode_t;

  typedef struct packed {
    logic                     is_valid;
    logic [RC_BUF_SIZE_LOG:0] tag;
    logic [31:0]              result;
    ex_mode_t                 mode;
    logic                     is_branch_established;
    logic [31:0]              jumped_to;
  } ex_result_t;
endpackage

// Per-lane writeback qualification: live-range check and age relative to head.
module reorder_commit_lane #(
  parameter int TW = 4,
  parameter int N  = 8
) (
  input  logic [TW-1:0] head,
  input  logic [TW-1:0] count,
  input  logic [N-1:0]  ent_valid,
  input  logic          vld,
  input  logic [TW-1:0] tag,
  input  logic          br_est,
  output logic          accept,
  output logic          branch,
  output logic [TW-1:0] age
);
  // tag-head modulo the pointer space; live iff it falls below count
  assign age    = tag - head;
  assign accept = vld & (age < count) & ent_valid[tag[TW-2:0]];
  assign branch = accept & br_est;
endmodule

module reorder_commit
  import reorder_commit_pkg::*;
#(
  parameter int BUF_SIZE_LOG = RC_BUF_SIZE_LOG
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [1:0]                  alloc_valid,
  input  logic [1:0][4:0]             alloc_rd,
  output logic                        alloc_ready,
  output logic [1:0][BUF_SIZE_LOG:0]  alloc_tag,
  input  ex_result_t [1:0]            results,
  output logic [1:0]                  commit_valid,
  output logic [1:0]                  commit_we,
  output logic [1:0][4:0]             commit_rd,
  output logic [1:0][31:0]            commit_value,
  output logic                        redirect_valid,
  output logic [31:0]                 redirect_pc,
  output logic                        empty
);
  localparam int TW = BUF_SIZE_LOG + 1;
  localparam int IW = BUF_SIZE_LOG;
  localparam int N  = 1 << BUF_SIZE_LOG;
  typedef logic [TW-1:0] ptr_t;

  ptr_t head, tail, count, n_alloc, n_commit;
  logic [N-1:0]       ent_valid, ent_done, ent_normal, squash_mask;
  logic [N-1:0][4:0]  ent_rd;
  logic [N-1:0][31:0] ent_value;

  logic [1:0]         wb_acc, wb_br, wb_keep;
  logic [1:0][TW-1:0] wb_age;
  logic               squash, win_lane, do_alloc;
  ptr_t               win_tag, win_age;
  logic [31:0]        win_pc;
  logic [IW-1:0]      hi0, hi1;

  assign count = tail - head;
  assign empty = (head == tail);

  for (genvar i = 0; i < 2; i++) begin : g_lane
    reorder_commit_lane #(.TW(TW), .N(N)) u_lane (
      .head      (head),
      .count     (count),
      .ent_valid (ent_valid),
      .vld       (results[i].is_valid),
      .tag       (results[i].tag),
      .br_est    (results[i].is_branch_established),
      .accept    (wb_acc[i]),
      .branch    (wb_br[i]),
      .age       (wb_age[i])
    );
  end

  // Squash arbitration: the older branch wins; younger writebacks are dropped.
  always_comb begin
    squash   = |wb_br;
    win_lane = wb_br[1] & (~wb_br[0] | (wb_age[1] < wb_age[0]));
    win_tag  = results[win_lane].tag;
    win_age  = wb_age[win_lane];
    win_pc   = results[win_lane].jumped_to;
    for (int i = 0; i < 2; i++)
      wb_keep[i] = wb_acc[i] & ~(squash & (wb_age[i] > win_age));
  end

  // Entries strictly younger than the winning branch, up to the old tail.
  always_comb begin
    squash_mask = '0;
    for (int k = 0; k < N; k++) begin
      if (squash && (ptr_t'(k) > win_age) && (ptr_t'(k) < count))
        squash_mask[IW'(head[IW-1:0] + IW'(k))] = 1'b1;
    end
  end

  // Allocation gating; free space uses pre-edge occupancy only.
  always_comb begin
    n_alloc      = alloc_valid[0] ? (alloc_valid[1] ? ptr_t'(2) : ptr_t'(1)) : ptr_t'(0);
    alloc_ready  = (count <= ptr_t'(N - 2)) & ~squash;
    do_alloc     = alloc_valid[0] & alloc_ready;
    alloc_tag[0] = tail;
    alloc_tag[1] = tail + ptr_t'(1);
  end

  // Commit selection from registered state only.
  always_comb begin
    hi0             = head[IW-1:0];
    hi1             = hi0 + IW'(1);
    commit_valid[0] = ent_valid[hi0] & ent_done[hi0];
    commit_valid[1] = commit_valid[0] & (count >= ptr_t'(2)) & ent_valid[hi1] & ent_done[hi1];
    commit_rd[0]    = ent_rd[hi0];
    commit_rd[1]    = ent_rd[hi1];
    commit_value[0] = ent_value[hi0];
    commit_value[1] = ent_value[hi1];
    commit_we[0]    = commit_valid[0] & ent_normal[hi0] & (|ent_rd[hi0]);
    commit_we[1]    = commit_valid[1] & ent_normal[hi1] & (|ent_rd[hi1]);
    n_commit        = commit_valid[1] ? ptr_t'(2) : (commit_valid[0] ? ptr_t'(1) : ptr_t'(0));
  end

  // Buffer state: writeback, squash, allocate, retire (later writes win).
  always_ff @(posedge clk) begin
    if (reset) begin
      head           <= '0;
      tail           <= '0;
      ent_valid      <= '0;
      ent_done       <= '0;
      ent_normal     <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (wb_keep[i]) begin
          ent_done[results[i].tag[IW-1:0]]   <= 1'b1;
          ent_value[results[i].tag[IW-1:0]]  <= results[i].result;
          ent_normal[results[i].tag[IW-1:0]] <= (results[i].mode == EX_NORMAL);
        end
      end
      for (int j = 0; j < N; j++) begin
        if (squash_mask[j]) begin
          ent_valid[j] <= 1'b0;
          ent_done[j]  <= 1'b0;
        end
      end
      if (do_alloc) begin
        ent_valid[tail[IW-1:0]] <= 1'b1;
        ent_done[tail[IW-1:0]]  <= 1'b0;
        ent_rd[tail[IW-1:0]]    <= alloc_rd[0];
        if (alloc_valid[1]) begin
          ent_valid[alloc_tag[1][IW-1:0]] <= 1'b1;
          ent_done[alloc_tag[1][IW-1:0]]  <= 1'b0;
          ent_rd[alloc_tag[1][IW-1:0]]    <= alloc_rd[1];
        end
      end
      if (commit_valid[0]) begin
        ent_valid[hi0] <= 1'b0;
        ent_done[hi0]  <= 1'b0;
      end
      if (commit_valid[1]) begin
        ent_valid[hi1] <= 1'b0;
        ent_done[hi1]  <= 1'b0;
      end
      head <= head + n_commit;
      if (squash)        tail <= win_tag + ptr_t'(1);
      else if (do_alloc) tail <= tail + n_alloc;
      redirect_valid <= squash;
      if (squash) redirect_pc <= win_pc;
    end
  end
endmodule

// File: tb/tb_reorder_commit.sv
// Scoreboard bench: a queue-of-entries reference model predicts every cycle's
// outputs; a negedge monitor pops and compares.
module tb_reorder_commit;
  import reorder_commit_pkg::*;
  localparam int N = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0]       alloc_valid = '0;
  logic [1:0][4:0]  alloc_rd = '0;
  logic             alloc_ready;
  logic [1:0][3:0]  alloc_tag;
  ex_result_t [1:0] results = '0;
  logic [1:0]       commit_valid, commit_we;
  logic [1:0][4:0]  commit_rd;
  logic [1:0][31:0] commit_value;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             empty;

  always #5 clk = ~clk;

  reorder_commit dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .results(results),
    .commit_valid(commit_valid), .commit_we(commit_we),
    .commit_rd(commit_rd), .commit_value(commit_value),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .empty(empty)
  );

  // reference model: program-ordered list of live entries
  typedef struct { logic [4:0] rd; bit done; bit normal; logic [31:0] val; } ment_t;
  ment_t live[$];
  int head_m = 0, tail_m = 0;
  bit redir_m = 0;
  logic [31:0] pc_m = '0;

  typedef struct {
    bit ready; logic [3:0] tag0, tag1; bit empty; bit [1:0] cv, we;
    logic [4:0] rd0, rd1; logic [31:0] v0, v1; bit rv; logic [31:0] rpc;
  } exp_t;
  exp_t expq[$];

  int errors = 0, checks = 0;
  localparam ex_result_t NOWB = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor
  always @(negedge clk) begin : mon
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("alloc_ready", 32'(alloc_ready), 32'(e.ready));
      chk("alloc_tag0", 32'(alloc_tag[0]), 32'(e.tag0));
      chk("alloc_tag1", 32'(alloc_tag[1]), 32'(e.tag1));
      chk("empty", 32'(empty), 32'(e.empty));
      chk("commit_valid", 32'(commit_valid), 32'(e.cv));
      chk("redirect_valid", 32'(redirect_valid), 32'(e.rv));
      chk("redirect_pc", redirect_pc, e.rpc);
      if (e.cv[0]) begin
        chk("commit_rd0", 32'(commit_rd[0]), 32'(e.rd0));
        chk("commit_value0", commit_value[0], e.v0);
        chk("commit_we0", 32'(commit_we[0]), 32'(e.we[0]));
      end
      if (e.cv[1]) begin
        chk("commit_rd1", 32'(commit_rd[1]), 32'(e.rd1));
        chk("commit_value1", commit_value[1], e.v1);
        chk("commit_we1", 32'(commit_we[1]), 32'(e.we[1]));
      end
    end
  end

  function automatic ex_result_t wb(input int tag, input logic [31:0] v, input bit br, input logic [31:0] pc);
    ex_result_t r;
    r = '0;
    r.is_valid = 1'b1;
    r.tag = 4'(tag & 15);
    r.result = v;
    r.mode = EX_NORMAL;
    r.is_branch_established = br;
    r.jumped_to = pc;
    return r;
  endfunction

  // one cycle: drive inputs, predict outputs, advance the model past the edge
  task automatic step(input logic [1:0] av, input logic [4:0] r0d, input logic [4:0] r1d,
                      input ex_result_t w0, input ex_result_t w1);
    exp_t e;
    ex_result_t w[2];
    int age[2];
    bit acc[2], br[2];
    bit sq;
    int wl, win_age, ncom, n;
    ment_t m;
    @(posedge clk); #1;
    reset = 1'b0;
    alloc_valid = av; alloc_rd[0] = r0d; alloc_rd[1] = r1d;
    results[0] = w0; results[1] = w1;
    w[0] = w0; w[1] = w1;
    ncom = 0;
    if (live.size() > 0 && live[0].done) begin
      ncom = 1;
      if (live.size() > 1 && live[1].done) ncom = 2;
    end
    for (int i = 0; i < 2; i++) begin
      age[i] = (int'(w[i].tag) - head_m) & 15;
      acc[i] = w[i].is_valid && (age[i] < live.size());
      br[i]  = acc[i] && w[i].is_branch_established;
    end
    sq = br[0] || br[1];
    wl = (br[0] && br[1]) ? ((age[1] < age[0]) ? 1 : 0) : (br[1] ? 1 : 0);
    win_age = age[wl];
    e = '{default: 0};
    e.ready = (live.size() <= N - 2) && !sq;
    e.tag0 = 4'(tail_m);
    e.tag1 = 4'((tail_m + 1) & 15);
    e.empty = (live.size() == 0);
    e.cv = (ncom == 2) ? 2'b11 : ((ncom == 1) ? 2'b01 : 2'b00);
    if (ncom >= 1) begin
      e.rd0 = live[0].rd; e.v0 = live[0].val;
      e.we[0] = live[0].normal && (live[0].rd != 0);
    end
    if (ncom == 2) begin
      e.rd1 = live[1].rd; e.v1 = live[1].val;
      e.we[1] = live[1].normal && (live[1].rd != 0);
    end
    e.rv = redir_m; e.rpc = pc_m;
    expq.push_back(e);
    for (int i = 0; i < 2; i++) begin
      if (acc[i] && (!sq || age[i] <= win_age)) begin
        live[age[i]].done = 1;
        live[age[i]].val = w[i].result;
        live[age[i]].normal = (w[i].mode == EX_NORMAL);
      end
    end
    if (sq) begin
      while (live.size() > win_age + 1) void'(live.pop_back());
      tail_m = (int'(w[wl].tag) + 1) & 15;
    end
    n = av[0] ? (av[1] ? 2 : 1) : 0;
    if (n > 0 && e.ready) begin
      for (int k = 0; k < n; k++) begin
        m.rd = (k == 0) ? r0d : r1d; m.done = 0; m.normal = 0; m.val = '0;
        live.push_back(m);
        tail_m = (tail_m + 1) & 15;
      end
    end
    for (int k = 0; k < ncom; k++) begin
      void'(live.pop_front());
      head_m = (head_m + 1) & 15;
    end
    redir_m = sq;
    if (sq) pc_m = w[wl].jumped_to;
  endtask

  task automatic idle();
    step(2'b00, 5'd0, 5'd0, NOWB, NOWB);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    alloc_valid = '0;
    results = '0;
    live.delete();
    head_m = 0; tail_m = 0; redir_m = 0; pc_m = '0;
  endtask

  // complete every outstanding entry, two per cycle, and let them retire
  task automatic drain();
    ex_result_t w[2];
    int j;
    for (int it = 0; it < 40 && live.size() > 0; it++) begin
      w[0] = NOWB; w[1] = NOWB; j = 0;
      for (int k = 0; k < live.size() && j < 2; k++) begin
        if (!live[k].done) begin
          w[j] = wb(head_m + k, $urandom, 1'b0, 32'h0);
          j++;
        end
      end
      step(2'b00, 5'd0, 5'd0, w[0], w[1]);
    end
    idle();
  endtask

  task automatic rand_step();
    ex_result_t w[2];
    int k;
    for (int i = 0; i < 2; i++) begin
      w[i] = NOWB;
      if ($urandom_range(0, 1) == 1) begin
        w[i].is_valid = 1'b1;
        w[i].result = $urandom;
        w[i].mode = ($urandom_range(0, 3) == 0) ? ex_mode_t'(2'($urandom_range(1, 3))) : EX_NORMAL;
        w[i].jumped_to = $urandom;
        if (live.size() > 0 && $urandom_range(0, 3) != 0) begin
          k = $urandom_range(0, live.size() - 1);
          w[i].tag = 4'((head_m + k) & 15);
          if (!live[k].done && $urandom_range(0, 5) == 0) w[i].is_branch_established = 1'b1;
        end else begin
          w[i].tag = 4'($urandom_range(0, 15));
        end
      end
    end
    step(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), w[0], w[1]);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    // reset state
    idle();
    // two allocations completing out of order, retired together
    step(2'b11, 5'd5, 5'd6, NOWB, NOWB);
    step(2'b00, 5'd0, 5'd0, wb(1, 32'hBB, 0, 0), NOWB);
    step(2'b00, 5'd0, 5'd0, wb(0, 32'hAA, 0, 0), NOWB);
    idle();
    idle();
    // fill to 7, refused request, retire one, fill to full
    step(2'b11, 5'd1, 5'd2, NOWB, NOWB);
    step(2'b11, 5'd3, 5'd4, NOWB, NOWB);
    step(2'b11, 5'd5, 5'd6, NOWB, NOWB);
    step(2'b01, 5'd7, 5'd0, NOWB, NOWB);
    step(2'b01, 5'd8, 5'd0, NOWB, NOWB);
    step(2'b00, 5'd0, 5'd0, wb(head_m, 32'h11, 0, 0), NOWB);
    idle();
    step(2'b11, 5'd9, 5'd10, NOWB, NOWB);
    step(2'b11, 5'd11, 5'd12, NOWB, NOWB);
    drain();
    // single branch squash, then writeback to a squashed tag
    do_reset();
    step(2'b11, 5'd1, 5'd2, NOWB, NOWB);
    step(2'b11, 5'd3, 5'd4, NOWB, NOWB);
    step(2'b11, 5'd5, 5'd6, NOWB, NOWB);
    step(2'b00, 5'd0, 5'd0, wb(2, 32'h22, 1, 32'h100), NOWB);
    idle();
    step(2'b00, 5'd0, 5'd0, wb(4, 32'h44, 0, 0), NOWB);
    drain();
    // both lanes branch; older (lane 1) wins; allocation refused
    do_reset();
    step(2'b11, 5'd1, 5'd2, NOWB, NOWB);
    step(2'b11, 5'd3, 5'd4, NOWB, NOWB);
    step(2'b11, 5'd5, 5'd6, NOWB, NOWB);
    step(2'b00, 5'd0, 5'd0, wb(0, 32'h10, 0, 0), NOWB);
    idle();
    step(2'b11, 5'd7, 5'd8, wb(4, 32'h40, 1, 32'h400), wb(2, 32'h20, 1, 32'h200));
    idle();
    drain();
    // phase wrap and a stale-phase result
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(2'b01, 5'(i + 1), 5'd0, NOWB, NOWB);
      if (i == 9) step(2'b00, 5'd0, 5'd0, wb(1, 32'hDEAD, 0, 0), NOWB);
      step(2'b00, 5'd0, 5'd0, wb(i, 32'h1000 + 32'(i), 0, 0), NOWB);
      idle();
    end
    // randomized traffic with a reset in the middle
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      rand_step();
    end
    drain();
    repeat (2) @(posedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
